// File: rtl/regfile_write_queue.sv
// Register write-back queue feeding the RegisterFile write port, with a per-register pending-write scoreboard.
// Optional macro WBQ_BYPASS_EN: an accept into an empty, draining queue loads the output stage directly.
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_dst,
    input  logic [15:0]              in_data,
    input  logic                     in_llb,
    input  logic                     in_lhb,
    input  logic                     drain_en,
    output logic [3:0]               DstReg,
    output logic                     WriteReg,
    output logic [15:0]              writedata,
    output logic                     LLB,
    output logic                     LHB,
    input  logic [3:0]               qry_reg1,
    input  logic [3:0]               qry_reg2,
    output logic                     qry_busy1,
    output logic                     qry_busy2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]       fifo_dst_q  [DEPTH];
    logic [15:0]      fifo_data_q [DEPTH];
    logic             fifo_llb_q  [DEPTH];
    logic             fifo_lhb_q  [DEPTH];

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic [3:0]       dst_q, dst_d;
    logic [15:0]      data_q, data_d;
    logic             llb_q, llb_d;
    logic             lhb_q, lhb_d;
    logic             wr_q, wr_d;

    logic [CNT_W-1:0] sb_q [16];
    logic [CNT_W-1:0] sb_d [16];

    logic             in_ready_s;
    logic             accept_s;
    logic             keep_s;
    logic             pop_s;
    logic             bypass_s;
    logic             push_s;
    logic             llb_in_s;

    assign in_ready_s = (count_q < CW'(DEPTH));
    assign accept_s   = in_valid && in_ready_s;
    // R0 is hardwired: such requests are acknowledged but never stored or tracked.
    assign keep_s     = accept_s && (in_dst != 4'd0);
    assign pop_s      = (count_q != {CW{1'b0}}) && drain_en;
`ifdef WBQ_BYPASS_EN
    assign bypass_s   = keep_s && drain_en && (count_q == {CW{1'b0}});
`else
    assign bypass_s   = 1'b0;
`endif
    assign push_s     = keep_s && !bypass_s;
    assign llb_in_s   = in_llb && !in_lhb;

    // Pointer, occupancy and output-stage next state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dst_d   = dst_q;
        data_d  = data_q;
        llb_d   = llb_q;
        lhb_d   = lhb_q;
        wr_d    = 1'b0;

        if (push_s) begin
            tail_d = tail_q + PW'(1'b1);
        end else begin
            tail_d = tail_q;
        end

        if (pop_s) begin
            head_d = head_q + PW'(1'b1);
            dst_d  = fifo_dst_q[head_q];
            data_d = fifo_data_q[head_q];
            llb_d  = fifo_llb_q[head_q];
            lhb_d  = fifo_lhb_q[head_q];
            wr_d   = 1'b1;
        end else if (bypass_s) begin
            dst_d  = in_dst;
            data_d = in_data;
            llb_d  = llb_in_s;
            lhb_d  = in_lhb;
            wr_d   = 1'b1;
        end else begin
            wr_d   = 1'b0;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1'b1);
            2'b01:   count_d = count_q - CW'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Scoreboard: +1 when a write is accepted, -1 when it commits; both together cancel.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            sb_d[i] = sb_q[i];
            case ({keep_s && (in_dst == 4'(i)), wr_q && (dst_q == 4'(i))})
                2'b10:   sb_d[i] = sb_q[i] + CNT_W'(1'b1);
                2'b01:   sb_d[i] = sb_q[i] - CNT_W'(1'b1);
                default: sb_d[i] = sb_q[i];
            endcase
        end
    end

    // Control, output-stage and scoreboard registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
            dst_q   <= 4'd0;
            data_q  <= 16'd0;
            llb_q   <= 1'b0;
            lhb_q   <= 1'b0;
            wr_q    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                sb_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            llb_q   <= llb_d;
            lhb_q   <= lhb_d;
            wr_q    <= wr_d;
            for (int i = 0; i < 16; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    // FIFO storage, written at the tail on every stored accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_dst_q[i]  <= 4'd0;
                fifo_data_q[i] <= 16'd0;
                fifo_llb_q[i]  <= 1'b0;
                fifo_lhb_q[i]  <= 1'b0;
            end
        end else if (push_s) begin
            fifo_dst_q[tail_q]  <= in_dst;
            fifo_data_q[tail_q] <= in_data;
            fifo_llb_q[tail_q]  <= llb_in_s;
            fifo_lhb_q[tail_q]  <= in_lhb;
        end
    end

    assign in_ready  = in_ready_s;
    assign count     = count_q;
    assign DstReg    = dst_q;
    assign WriteReg  = wr_q;
    assign writedata = data_q;
    assign LLB       = llb_q;
    assign LHB       = lhb_q;
    assign qry_busy1 = (qry_reg1 != 4'd0) && (sb_q[qry_reg1] != {CNT_W{1'b0}});
    assign qry_busy2 = (qry_reg2 != 4'd0) && (sb_q[qry_reg2] != {CNT_W{1'b0}});

endmodule
